// File: rtl/pipeline_pkg.sv
// Shared definitions for the execute stage: ALU op codes, FSM encoding,
// multiplier iteration count and the EX/MEM payload record.
package pipeline_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int MUL_ITERS = 32;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  waddr;
    logic        wreg;
    logic        wmem;
    logic        wb_sel;
    logic        jump;
    logic [31:0] jump_pc;
  } mem_t;

endpackage

// File: rtl/iter_mul32.sv
// 32-iteration shift-add multiplier; done flags the final iteration cycle and
// product holds the low 32 bits of a*b from the following cycle on.
module iter_mul32
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] product
);

  localparam logic [5:0] LAST_ITER = 6'(MUL_ITERS - 1);

  logic [31:0] mcand_d, mcand_q;
  logic [31:0] mplier_d, mplier_q;
  logic [31:0] acc_d, acc_q;
  logic [5:0]  cnt_d, cnt_q;
  logic        run_d, run_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 6'd1;
      if (cnt_q == LAST_ITER) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  assign done    = run_q && (cnt_q == LAST_ITER);
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM register: single-cycle ALU plus an iterative
// multiply that holds EX busy for 33 cycles and then emits one DONE slot.
module ex_stage
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_shiftAmount,
  input  logic [31:0] ex_immediate,
  input  logic [31:0] ex_registerRsOrPc_4,
  input  logic [31:0] ex_registerRtOrZero,
  input  logic [3:0]  ex_aluOperation,
  input  logic [4:0]  ex_registerWriteAddress,
  input  logic        ex_ifWriteRegsFile,
  input  logic        ex_ifWriteMem,
  input  logic        ex_memOutOrAluOutWriteBackToRegFile,
  input  logic        ex_whileShiftAluInput_A_UseShamt,
  input  logic        ex_aluInput_B_UseRtOrImmeidate,
  input  logic        ex_shouldJumpOrBranch,
  input  logic [31:0] ex_jumpOrBranchPc,
  output logic        ex_busy,
  output logic [31:0] mem_aluResult,
  output logic [31:0] mem_storeData,
  output logic [4:0]  mem_registerWriteAddress,
  output logic        mem_ifWriteRegsFile,
  output logic        mem_ifWriteMem,
  output logic        mem_memOutOrAluOutWriteBackToRegFile,
  output logic        mem_shouldJumpOrBranch,
  output logic [31:0] mem_jumpOrBranchPc
);

  logic [1:0]  state_d, state_q;
  mem_t        cur_s, mem_d, mem_q, lat_d, lat_q;
  logic [31:0] alu_a, alu_b, alu_res, mul_product;
  logic        mul_start, mul_done;

  assign alu_a = ex_whileShiftAluInput_A_UseShamt ? ex_shiftAmount : ex_registerRsOrPc_4;
  assign alu_b = ex_aluInput_B_UseRtOrImmeidate ? ex_immediate : ex_registerRtOrZero;

  // MUL is not computed here; it only reaches EX/MEM via the iterative unit.
  always_comb begin
    alu_res = '0;
    case (ex_aluOperation)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_NOR:  alu_res = ~(alu_a | alu_b);
      ALU_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'd0, alu_a < alu_b};
      ALU_SLL:  alu_res = alu_b << alu_a[4:0];
      ALU_SRL:  alu_res = alu_b >> alu_a[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> alu_a[4:0]);
      ALU_LUI:  alu_res = {alu_b[15:0], 16'd0};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    cur_s            = '0;
    cur_s.result     = alu_res;
    cur_s.store_data = ex_registerRtOrZero;
    cur_s.waddr      = ex_registerWriteAddress;
    cur_s.wreg       = ex_ifWriteRegsFile;
    cur_s.wmem       = ex_ifWriteMem;
    cur_s.wb_sel     = ex_memOutOrAluOutWriteBackToRegFile;
    cur_s.jump       = ex_shouldJumpOrBranch;
    cur_s.jump_pc    = ex_jumpOrBranchPc;
  end

  assign mul_start = (state_q == ST_IDLE) && (ex_aluOperation == ALU_MUL);
  assign ex_busy   = mul_start || (state_q == ST_MUL);

  iter_mul32 u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (alu_a),
    .b       (alu_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // EX/MEM defaults to a bubble; only IDLE non-MUL and DONE write real data.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    mem_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (ex_aluOperation == ALU_MUL) begin
          lat_d   = cur_s;
          state_d = ST_MUL;
        end else begin
          mem_d = cur_s;
        end
      end
      ST_MUL: begin
        if (mul_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        mem_d        = lat_q;
        mem_d.result = mul_product;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      mem_q   <= mem_d;
    end
  end

  assign mem_aluResult                        = mem_q.result;
  assign mem_storeData                        = mem_q.store_data;
  assign mem_registerWriteAddress             = mem_q.waddr;
  assign mem_ifWriteRegsFile                  = mem_q.wreg;
  assign mem_ifWriteMem                       = mem_q.wmem;
  assign mem_memOutOrAluOutWriteBackToRegFile = mem_q.wb_sel;
  assign mem_shouldJumpOrBranch               = mem_q.jump;
  assign mem_jumpOrBranchPc                   = mem_q.jump_pc;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a cycle-timeline model of the stage is
// compared every cycle, with directed literal checks pinning key results.
module tb_ex_stage;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  waddr;
    logic        wreg;
    logic        wmem;
    logic        wb_sel;
    logic        jump;
    logic [31:0] jump_pc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] shamt, imm, rs, rt, jpc;
  logic [3:0]  op;
  logic [4:0]  waddr;
  logic        wreg, wmem, wb, use_shamt, use_imm, jmp;

  logic        ex_busy;
  logic [31:0] mem_aluResult, mem_storeData, mem_jumpOrBranchPc;
  logic [4:0]  mem_registerWriteAddress;
  logic        mem_ifWriteRegsFile, mem_ifWriteMem, mem_memOutOrAluOutWriteBackToRegFile;
  logic        mem_shouldJumpOrBranch;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                                  (clk),
    .rst                                  (rst),
    .ex_shiftAmount                       (shamt),
    .ex_immediate                         (imm),
    .ex_registerRsOrPc_4                  (rs),
    .ex_registerRtOrZero                  (rt),
    .ex_aluOperation                      (op),
    .ex_registerWriteAddress              (waddr),
    .ex_ifWriteRegsFile                   (wreg),
    .ex_ifWriteMem                        (wmem),
    .ex_memOutOrAluOutWriteBackToRegFile  (wb),
    .ex_whileShiftAluInput_A_UseShamt     (use_shamt),
    .ex_aluInput_B_UseRtOrImmeidate       (use_imm),
    .ex_shouldJumpOrBranch                (jmp),
    .ex_jumpOrBranchPc                    (jpc),
    .ex_busy                              (ex_busy),
    .mem_aluResult                        (mem_aluResult),
    .mem_storeData                        (mem_storeData),
    .mem_registerWriteAddress             (mem_registerWriteAddress),
    .mem_ifWriteRegsFile                  (mem_ifWriteRegsFile),
    .mem_ifWriteMem                       (mem_ifWriteMem),
    .mem_memOutOrAluOutWriteBackToRegFile (mem_memOutOrAluOutWriteBackToRegFile),
    .mem_shouldJumpOrBranch               (mem_shouldJumpOrBranch),
    .mem_jumpOrBranchPc                   (mem_jumpOrBranchPc)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_alu(logic [3:0] o, logic [31:0] a, logic [31:0] b);
    logic [4:0] s;
    s = a[4:0];
    case (o)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << s;
      4'd9:  return b >> s;
      4'd10: return $unsigned($signed(b) >>> s);
      4'd11: return b << 16;
      4'd12: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic rec_t cur_rec(logic [31:0] res);
    rec_t r;
    r.result = res; r.store_data = rt; r.waddr = waddr; r.wreg = wreg;
    r.wmem = wmem; r.wb_sel = wb; r.jump = jmp; r.jump_pc = jpc;
    return r;
  endfunction

  int   cyc = 0;
  int   mul_start = 0;
  bit   mul_active = 1'b0;
  bit   model_valid = 1'b0;
  rec_t exp_mem = '0;
  rec_t mul_rec = '0;

  // A MUL presented at cycle t occupies t..t+33; its record lands at t+34.
  always @(posedge clk) begin
    logic [31:0] a, b;
    a = use_shamt ? shamt : rs;
    b = use_imm ? imm : rt;
    cyc <= cyc + 1;
    if (rst) begin
      model_valid <= 1'b1;
      mul_active  <= 1'b0;
      exp_mem     <= '0;
    end else if (mul_active) begin
      if (cyc == mul_start + 33) begin
        exp_mem    <= mul_rec;
        mul_active <= 1'b0;
      end else begin
        exp_mem <= '0;
      end
    end else if (op == 4'd12) begin
      mul_active <= 1'b1;
      mul_start  <= cyc;
      mul_rec    <= cur_rec(model_alu(op, a, b));
      exp_mem    <= '0;
    end else begin
      exp_mem <= cur_rec(model_alu(op, a, b));
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      logic exp_busy;
      exp_busy = mul_active ? (cyc <= mul_start + 32) : (op == 4'd12);
      check("busy",   {31'd0, ex_busy}, {31'd0, exp_busy});
      check("result", mem_aluResult, exp_mem.result);
      check("store",  mem_storeData, exp_mem.store_data);
      check("waddr",  {27'd0, mem_registerWriteAddress}, {27'd0, exp_mem.waddr});
      check("wreg",   {31'd0, mem_ifWriteRegsFile}, {31'd0, exp_mem.wreg});
      check("wmem",   {31'd0, mem_ifWriteMem}, {31'd0, exp_mem.wmem});
      check("wb_sel", {31'd0, mem_memOutOrAluOutWriteBackToRegFile}, {31'd0, exp_mem.wb_sel});
      check("jump",   {31'd0, mem_shouldJumpOrBranch}, {31'd0, exp_mem.jump});
      check("jump_pc", mem_jumpOrBranchPc, exp_mem.jump_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    shamt = '0; imm = '0; rs = '0; rt = '0; jpc = '0; op = '0; waddr = '0;
    wreg = 0; wmem = 0; wb = 0; use_shamt = 0; use_imm = 0; jmp = 0;
  endtask

  task automatic set_op(logic [3:0] o, logic [31:0] a_rs, logic [31:0] b_rt, logic [4:0] wa);
    bubble();
    op = o; rs = a_rs; rt = b_rt; waddr = wa; wreg = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    bit seen_product;
    logic [3:0] ops [11];

    // Reset with non-zero inputs.
    rst = 1'b1;
    shamt = 32'h1F; imm = 32'h1234; rs = 32'hDEAD; rt = 32'hBEEF; jpc = 32'h400;
    op = 4'd3; waddr = 5'd17; wreg = 1; wmem = 1; wb = 1; use_shamt = 0; use_imm = 1; jmp = 1;
    cycle();
    cycle();
    check("rst_result", mem_aluResult, 32'd0);
    check("rst_wreg", {31'd0, mem_ifWriteRegsFile}, 32'd0);
    check("rst_jump", {31'd0, mem_shouldJumpOrBranch}, 32'd0);
    check("rst_busy", {31'd0, ex_busy}, 32'd0);
    rst = 1'b0;

    // ADD immediate.
    set_op(4'd0, 32'd5, 32'd0, 5'd7);
    imm = 32'hFFFF_FFFD; use_imm = 1'b1;
    cycle();
    check("add_imm_result", mem_aluResult, 32'd2);
    check("add_imm_waddr", {27'd0, mem_registerWriteAddress}, 32'd7);

    // Shifts and compares.
    set_op(4'd10, 32'd0, 32'h8000_0000, 5'd1); use_shamt = 1'b1; shamt = 32'd4;
    cycle();
    check("sra", mem_aluResult, 32'hF800_0000);
    set_op(4'd9, 32'd0, 32'h8000_0000, 5'd1); use_shamt = 1'b1; shamt = 32'd4;
    cycle();
    check("srl", mem_aluResult, 32'h0800_0000);
    set_op(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd2);
    cycle();
    check("slt", mem_aluResult, 32'd1);
    set_op(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd2);
    cycle();
    check("sltu", mem_aluResult, 32'd0);
    set_op(4'd11, 32'd0, 32'd0, 5'd3); use_imm = 1'b1; imm = 32'h0000_ABCD;
    cycle();
    check("lui", mem_aluResult, 32'hABCD_0000);

    // Remaining ops, model-checked; store/mem controls exercised too.
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd13, 4'd14, 4'd15, 4'd6, 4'd7};
    for (int i = 0; i < 11; i++) begin
      set_op(ops[i], 32'h0F0F_1234 + 32'(i), 32'h80F0_FF01, 5'(i + 4));
      wmem = i[0]; wb = i[1]; use_shamt = (i == 5); shamt = 32'd3;
      cycle();
    end
    bubble();
    cycle();

    // MUL 0xFFFFFFFF * 3, busy duration and product timing.
    set_op(4'd12, 32'hFFFF_FFFF, 32'd3, 5'd9);
    #1;
    busy_cnt = ex_busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      bubble();
      #1;
      if (ex_busy) busy_cnt++;
      else break;
    end
    check("mul_busy_cycles", 32'(busy_cnt), 32'd33);
    cycle();
    check("mul_product", mem_aluResult, 32'hFFFF_FFFD);
    check("mul_waddr", {27'd0, mem_registerWriteAddress}, 32'd9);
    check("mul_wreg", {31'd0, mem_ifWriteRegsFile}, 32'd1);
    cycle();

    // Reset during a multiply: no product ever surfaces.
    set_op(4'd12, 32'd7, 32'd6, 5'd3);
    repeat (15) begin
      cycle();
      bubble();
    end
    rst = 1'b1;
    cycle();
    check("mid_rst_busy", {31'd0, ex_busy}, 32'd0);
    rst = 1'b0;
    seen_product = 1'b0;
    repeat (40) begin
      cycle();
      if (mem_aluResult == 32'd42 || mem_ifWriteRegsFile) seen_product = 1'b1;
    end
    check("mid_rst_no_product", {31'd0, seen_product}, 32'd0);

    // Back-to-back MULs: results at cycles 34 and 68.
    set_op(4'd12, 32'h0001_0001, 32'h0001_0001, 5'd5);
    repeat (33) begin
      cycle();
      bubble();
    end
    cycle();
    set_op(4'd12, 32'h1234_5678, 32'h10, 5'd6);
    #1;
    check("b2b_first", mem_aluResult, 32'h0002_0001);
    check("b2b_second_accepted", {31'd0, ex_busy}, 32'd1);
    repeat (34) begin
      cycle();
      bubble();
    end
    check("b2b_second", mem_aluResult, 32'h2345_6780);
    check("b2b_second_waddr", {27'd0, mem_registerWriteAddress}, 32'd6);

    // Redirect pass-through.
    bubble();
    jmp = 1'b1; jpc = 32'h0040_0020;
    cycle();
    check("redirect_flag", {31'd0, mem_shouldJumpOrBranch}, 32'd1);
    check("redirect_pc", mem_jumpOrBranchPc, 32'h0040_0020);
    bubble();
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
